s4ga_cfg_player: RTL

Configuration sequencer directly upstream of the s4ga serial LUT fabric. Captures one complete LUT-configuration frame (N LUTs × LL segments of SI_W bits) from a host load port into local storage. Then drives the fabric's reset and replays the frame on `si` continuously, one segment per clock, wrapping forever. It also flags the end of each fabric evaluation sweep.

---
 rtl/s4ga_pkg.sv | 32 +++
 rtl/s4ga_cfg_player_if.sv | 25 ++
 rtl/s4ga_cfg_mem.sv | 21 ++
 rtl/s4ga_cfg_player.sv | 130 +++++++++++++
 4 files changed

// File: rtl/s4ga_pkg.sv
// Shared geometry helpers for the s4ga fabric and its configuration player.
// Both blocks derive frame sizes from these functions, so their frame sizes always agree.
package s4ga_pkg;

    // Number of SI_W-bit segments needed to carry a field of the given width.
    function automatic int unsigned segs(input int unsigned bits, input int unsigned w);
        return (bits + w - 1) / w;
    endfunction

    function automatic int unsigned n_w(input int unsigned n);
        return $clog2(n);
    endfunction

    function automatic int unsigned idx_segs(input int unsigned n, input int unsigned si_w);
        return segs(n_w(n), si_w);
    endfunction

    function automatic int unsigned mask_segs(input int unsigned k, input int unsigned si_w);
        return segs(1 << k, si_w);
    endfunction

    function automatic int unsigned ll(input int unsigned n, input int unsigned k,
                                       input int unsigned si_w);
        return k * idx_segs(n, si_w) + mask_segs(k, si_w);
    endfunction

    function automatic int unsigned depth(input int unsigned n, input int unsigned k,
                                          input int unsigned si_w);
        return n * ll(n, k, si_w);
    endfunction

endpackage

// File: rtl/s4ga_cfg_player_if.sv
// Host load port and fabric-facing stream of the configuration player.
interface s4ga_cfg_player_if #(
    parameter int unsigned SI_W = 4
);
    logic            cfg_start;
    logic            load_valid;
    logic            load_ready;
    logic [SI_W-1:0] load_data;
    logic            load_last;
    logic [SI_W-1:0] si;
    logic            fpga_rst;
    logic            running;
    logic            frame_tick;
    logic            cfg_err;

    modport master (
        output cfg_start, load_valid, load_data, load_last,
        input  load_ready, si, fpga_rst, running, frame_tick, cfg_err
    );

    modport slave (
        input  cfg_start, load_valid, load_data, load_last,
        output load_ready, si, fpga_rst, running, frame_tick, cfg_err
    );
endinterface

// File: rtl/s4ga_cfg_mem.sv
// Frame storage: one synchronous write port, one synchronous read port, no reset,
// so it can be swapped for an SRAM macro.
module s4ga_cfg_mem #(
    parameter int unsigned DEPTH = 15,
    parameter int unsigned SI_W  = 4,
    parameter int unsigned A_W   = 4
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [A_W-1:0]  wr_addr,
    input  logic [SI_W-1:0] wr_data,
    input  logic [A_W-1:0]  rd_addr,
    output logic [SI_W-1:0] rd_data
);
    logic [SI_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/s4ga_cfg_player.sv
// Captures one LUT-configuration frame, holds the fabric in reset, then replays
// the frame on si one segment per clock, wrapping forever.
module s4ga_cfg_player
    import s4ga_pkg::*;
#(
    parameter int unsigned N          = 67,
    parameter int unsigned K          = 5,
    parameter int unsigned SI_W       = 4,
    parameter int unsigned RST_CYCLES = N + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    s4ga_cfg_player_if.slave  bus
);
    localparam int unsigned DEPTH = depth(N, K, SI_W);
    localparam int unsigned A_W   = $clog2(DEPTH);
    localparam int unsigned C_W   = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    state_t          state;
    logic [A_W-1:0]  waddr;
    logic [A_W-1:0]  raddr;
    logic [A_W-1:0]  rd_idx;
    logic [A_W-1:0]  last;
    logic [C_W-1:0]  cnt;
    logic [SI_W-1:0] rd_data;
    logic [SI_W-1:0] si;
    logic            fpga_rst;
    logic            running;
    logic            frame_tick;
    logic            cfg_err;
    logic            load_ready;
    logic            wr_en;

    always_comb begin
        load_ready = (state == LOAD);
        wr_en      = load_ready && bus.load_valid && !bus.cfg_start;
    end

    assign bus.load_ready = load_ready;
    assign bus.si         = si;
    assign bus.fpga_rst   = fpga_rst;
    assign bus.running    = running;
    assign bus.frame_tick = frame_tick;
    assign bus.cfg_err    = cfg_err;

    // last holds len-1, so the wrap compare needs no adder and len=2**A_W still fits.
    function automatic logic [A_W-1:0] nxt(input logic [A_W-1:0] a);
        return (a == last) ? '0 : a + 1'b1;
    endfunction

    s4ga_cfg_mem #(
        .DEPTH (DEPTH),
        .SI_W  (SI_W),
        .A_W   (A_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (waddr),
        .wr_data (bus.load_data),
        .rd_addr (raddr),
        .rd_data (rd_data)
    );

    // raddr runs one fetch ahead of si because the memory read is registered;
    // the last two FLUSH cycles prime the pipeline so RUN starts with mem[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            waddr      <= '0;
            raddr      <= '0;
            rd_idx     <= '0;
            last       <= '0;
            cnt        <= '0;
            si         <= '0;
            fpga_rst   <= 1'b1;
            running    <= 1'b0;
            frame_tick <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            rd_idx <= raddr;
            if (bus.cfg_start) begin
                state      <= LOAD;
                waddr      <= '0;
                raddr      <= '0;
                cnt        <= '0;
                cfg_err    <= 1'b0;
                si         <= '0;
                fpga_rst   <= 1'b1;
                running    <= 1'b0;
                frame_tick <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    LOAD: begin
                        if (wr_en) begin
                            waddr <= waddr + 1'b1;
                            if (bus.load_last || waddr == A_W'(DEPTH - 1)) begin
                                state   <= FLUSH;
                                last    <= waddr;
                                cfg_err <= (waddr != A_W'(DEPTH - 1));
                                cnt     <= '0;
                                raddr   <= '0;
                            end
                        end
                    end
                    FLUSH: begin
                        if (cnt >= C_W'(RST_CYCLES - 1)) raddr <= nxt(raddr);
                        if (cnt == C_W'(RST_CYCLES)) begin
                            state      <= RUN;
                            fpga_rst   <= 1'b0;
                            running    <= 1'b1;
                            si         <= rd_data;
                            frame_tick <= (rd_idx == last);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        raddr      <= nxt(raddr);
                        si         <= rd_data;
                        frame_tick <= (rd_idx == last);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
